// File: rtl/sob_stream_gen.sv
// Stochastic number generator: turns a WIDTH-bit value into a 2^WIDTH-bit unipolar stream.
// Optional macro SNG_LFSR_EN replaces the ramp random source with a de Bruijn LFSR.
module sob_stream_gen #(
  parameter int WIDTH = 5,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_in,
  input  logic             value_valid,
  output logic             value_ready,
  output logic             stream_out,
  output logic [WIDTH-1:0] counter_sob,
  output logic             enable,
  output logic             period_done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] value_q, value_nxt;
  logic [WIDTH-1:0] cnt_nxt, r_nxt;
  logic             enable_nxt, done_nxt, stream_nxt;
  logic             last_bit, accept, advance;

  assign last_bit    = (state == RUN) && (counter_sob == CNT_MAX);
  assign value_ready = (state == IDLE) || last_bit;
  assign accept      = value_valid && value_ready;
  assign advance     = (state == RUN) && !last_bit;

`ifdef SNG_LFSR_EN
  localparam logic [7:0] TAPS8 =
      (WIDTH == 3) ? 8'b0000_0110 :
      (WIDTH == 4) ? 8'b0000_1100 :
      (WIDTH == 5) ? 8'b0001_0100 :
      (WIDTH == 6) ? 8'b0011_0000 :
      (WIDTH == 7) ? 8'b0110_0000 : 8'b1011_1000;
  localparam logic [WIDTH-1:0] TAPS   = TAPS8[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q, lfsr_nxt;

  // Zero-state insertion stretches the maximal-length cycle to all 2^WIDTH states.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ (s[WIDTH-2:0] == '0);
    return {s[WIDTH-2:0], fb};
  endfunction

  always_comb begin
    lfsr_nxt = lfsr_q;
    if (accept)       lfsr_nxt = SEED_W;
    else if (advance) lfsr_nxt = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED_W;
    else      lfsr_q <= lfsr_nxt;
  end

  assign r_nxt = lfsr_nxt;
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign r_nxt       = cnt_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle view of the registered outputs; an accept always restarts at index 0.
  always_comb begin
    value_nxt  = value_q;
    cnt_nxt    = '0;
    enable_nxt = 1'b0;
    done_nxt   = 1'b0;
    if (accept) begin
      value_nxt  = value_in;
      enable_nxt = 1'b1;
    end else if (advance) begin
      cnt_nxt    = counter_sob + 1'b1;
      enable_nxt = 1'b1;
      done_nxt   = (cnt_nxt == CNT_MAX);
    end
  end

  assign stream_nxt = enable_nxt && (r_nxt < value_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q     <= '0;
      counter_sob <= '0;
      enable      <= 1'b0;
      period_done <= 1'b0;
      stream_out  <= 1'b0;
    end else begin
      value_q     <= value_nxt;
      counter_sob <= cnt_nxt;
      enable      <= enable_nxt;
      period_done <= done_nxt;
      stream_out  <= stream_nxt;
    end
  end

endmodule

// File: tb/tb_sob_stream_gen.sv
// Self-checking bench for sob_stream_gen: table-driven periods, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_sob_stream_gen;
  localparam int W = 5;
  localparam int P = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] value_in;
  logic         value_valid;
  logic         value_ready;
  logic         stream_out;
  logic [W-1:0] counter_sob;
  logic         enable;
  logic         period_done;

  int n_tests = 0;
  int n_fail  = 0;

  sob_stream_gen #(.WIDTH(W), .SEED(1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .stream_out(stream_out), .counter_sob(counter_sob),
    .enable(enable), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},    32'(enable), 0);
    chk({tag, "_cnt"},   32'(counter_sob), 0);
    chk({tag, "_bit"},   32'(stream_out), 0);
    chk({tag, "_done"},  32'(period_done), 0);
    chk({tag, "_ready"}, 32'(value_ready), 1);
  endtask

  // Caller has just sampled index 0 of a period; returns sampled at index P-1.
  task automatic observe_period(input string tag, input logic [W-1:0] v,
                                output int ones, output logic [P-1:0] bits);
    ones = 0;
    bits = '0;
    for (int i = 0; i < P; i++) begin
      if (i > 0) tick();
      chk({tag, "_en"},    32'(enable), 1);
      chk({tag, "_cnt"},   32'(counter_sob), 32'(i));
      chk({tag, "_done"},  32'(period_done), 32'(i == P-1));
      chk({tag, "_ready"}, 32'(value_ready), 32'(i == P-1));
`ifndef SNG_LFSR_EN
      chk({tag, "_bit"},   32'(stream_out), 32'(i < int'(v)));
`endif
      bits[i] = stream_out;
      ones += int'(stream_out);
    end
  endtask

  typedef struct {
    logic [W-1:0] value;
    int           exp_ones;
    logic         exp_bit0;
    logic         exp_bit_last;
  } vec_t;

  typedef struct {
    int   idx;
    logic b;
    int   v;
  } ent_t;

  initial begin
    vec_t         vecs[5];
    ent_t         q[$];
    ent_t         e;
    int           ones, ones2, acc;
    logic [P-1:0] bits, bits2;
    int           sel;

    vecs[0] = '{5'd12, 12, 1'b1, 1'b0};
    vecs[1] = '{5'd0,   0, 1'b0, 1'b0};
    vecs[2] = '{5'd31, 31, 1'b1, 1'b0};
    vecs[3] = '{5'd1,   1, 1'b1, 1'b0};
    vecs[4] = '{5'd16, 16, 1'b1, 1'b0};

    rst = 1'b0;
    value_in = '0;
    value_valid = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b1;
    tick();
    chk_idle("post_reset");

    foreach (vecs[k]) begin
      value_in = vecs[k].value;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      observe_period("table", vecs[k].value, ones, bits);
      chk("table_ones", 32'(ones), 32'(vecs[k].exp_ones));
`ifndef SNG_LFSR_EN
      chk("table_bit0", 32'(bits[0]), 32'(vecs[k].exp_bit0));
      chk("table_bit_last", 32'(bits[P-1]), 32'(vecs[k].exp_bit_last));
`endif
      tick();
      chk_idle("table_after");
    end

    // Back-to-back: valid held, second value queued while the first period runs.
    value_in = 5'd7;
    value_valid = 1'b1;
    tick();
    value_in = 5'd20;
    observe_period("b2b1", 5'd7, ones, bits);
    tick();
    value_valid = 1'b0;
    observe_period("b2b2", 5'd20, ones2, bits2);
    chk("b2b_ones1", 32'(ones), 7);
    chk("b2b_ones2", 32'(ones2), 20);
    tick();
    chk_idle("b2b_after");

    // Backpressure: value_in churns during RUN; only the last-index value is taken.
    value_in = 5'd3;
    value_valid = 1'b1;
    tick();
    ones = 0;
    for (int i = 0; i < P; i++) begin
      if (i > 0) tick();
      chk("bp_cnt", 32'(counter_sob), 32'(i));
      chk("bp_ready", 32'(value_ready), 32'(i == P-1));
      ones += int'(stream_out);
      value_in = (i == P-1) ? 5'd9 : W'($urandom);
    end
    chk("bp_ones1", 32'(ones), 3);
    tick();
    value_valid = 1'b0;
    value_in = 5'd30;
    observe_period("bp2", 5'd9, ones, bits);
    chk("bp_ones2", 32'(ones), 9);
    tick();
    chk_idle("bp_after");

    // Reset mid-period at index 17 aborts asynchronously.
    value_in = 5'd25;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (17) tick();
    chk("mr_cnt17", 32'(counter_sob), 17);
    #2 rst = 1'b0;
    #1;
    chk_idle("mid_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    chk_idle("mid_release");
    for (int i = 0; i < P + 8; i++) begin
      tick();
      chk("mr_no_done", 32'(period_done), 0);
      chk("mr_no_en", 32'(enable), 0);
    end

    // Randomized run against a queue of expected (index, bit) entries.
    q.delete();
    acc = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_en", 32'(enable), 1);
        chk("rnd_cnt", 32'(counter_sob), 32'(e.idx));
        chk("rnd_done", 32'(period_done), 32'(e.idx == P-1));
`ifndef SNG_LFSR_EN
        chk("rnd_bit", 32'(stream_out), 32'(e.b));
`else
        acc += int'(stream_out);
        if (e.idx == P-1) begin
          chk("rnd_ones", 32'(acc), 32'(e.v));
          acc = 0;
        end
`endif
      end else begin
        chk("rnd_idle_en", 32'(enable), 0);
        chk("rnd_idle_cnt", 32'(counter_sob), 0);
        chk("rnd_idle_bit", 32'(stream_out), 0);
      end
      chk("rnd_ready", 32'(value_ready), 32'(q.size() == 0));
      value_valid = ($urandom_range(0, 2) == 0);
      sel = int'($urandom_range(0, 7));
      value_in = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : W'($urandom);
      if (value_valid && q.size() == 0)
        for (int i = 0; i < P; i++) q.push_back('{i, (i < int'(value_in)), int'(value_in)});
      tick();
    end
    value_valid = 1'b0;
    repeat (P + 2) tick();
    chk_idle("rnd_drain");

`ifdef SNG_LFSR_EN
    // Exact popcount for every value implies the r sequence is a permutation of 0..P-1.
    for (int v = 0; v < P; v++) begin
      value_in = W'(v);
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      observe_period("lfsr_sweep", W'(v), ones, bits);
      chk("lfsr_sweep_ones", 32'(ones), 32'(v));
      tick();
    end
    value_in = 5'd16;
    value_valid = 1'b1;
    tick();
    observe_period("lfsr_p1", 5'd16, ones, bits);
    tick();
    value_valid = 1'b0;
    observe_period("lfsr_p2", 5'd16, ones2, bits2);
    chk("lfsr_ones1", 32'(ones), 16);
    chk("lfsr_ones2", 32'(ones2), 16);
    chk("lfsr_identical", bits, bits2);
    tick();
    chk_idle("lfsr_after");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sob_stream_gen.md
Name: sob_stream_gen

Overview:
- Stochastic number generator (SNG) that sits directly upstream of the decorrelator stage.
- Accepts a WIDTH-bit binary value over a valid/ready handshake and emits a unipolar bitstream of length 2^WIDTH containing exactly `value` ones.
- Also drives the shared sequence counter (counter_sob) and the enable strobe that the decorrelator consumes.
- Back-to-back periods stream without a gap.

Parameters:
- WIDTH, 5, bit width of value and of counter_sob; period = 2^WIDTH cycles; legal range 3..8.
- SEED, 1, LFSR state loaded at every period start (used only with SNG_LFSR_EN); any value is legal, truncated to WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- value_in  in  WIDTH  binary magnitude to encode (ones per period).
- value_valid  in  1  value_in valid.
- value_ready  out  1  block can accept value_in this cycle.
- stream_out  out  1  stochastic bit.
- counter_sob  out  WIDTH  index of the current stream_out bit within the period, 0..2^WIDTH-1.
- enable  out  1  stream_out/counter_sob valid this cycle.
- period_done  out  1  one-cycle pulse on the last bit of a period (counter_sob = 2^WIDTH-1).

Behaviour:
- All outputs are registered. Reset (rst=0, async) forces: FSM=IDLE, stream_out=0, counter_sob=0, enable=0, period_done=0, latched value=0, LFSR=SEED.
- value_ready is combinational from state: 1 in IDLE, 1 in RUN when counter_sob = 2^WIDTH-1, otherwise 0. Accept = value_valid & value_ready.
- FSM, IDLE:
  - Accept → latch value_in, RUN; next cycle counter_sob=0, enable=1, first bit valid. Latency is 1 cycle from accept to first bit.
  - No accept → stay; enable=0, stream_out=0, counter_sob holds 0.
- FSM, RUN:
  - Each cycle, counter_sob increments by 1 and enable=1.
  - stream_out = (r < latched value), unsigned WIDTH-bit compare. r is the random word for the current index.
- Last cycle of a period (counter_sob = 2^WIDTH-1): period_done=1.
  - Accept on this cycle → latch the new value; counter_sob wraps to 0 next cycle with no bubble.
  - No accept → IDLE next cycle; enable=0, counter_sob=0, stream_out=0.
- Random source, default: r = counter_sob (ramp). The period is thermometer-coded: ones at indices 0..value-1.
- Exactness: over every full period, popcount(stream_out) = latched value. value=0 gives all zeros; value=2^WIDTH-1 gives one zero, at the index where r = 2^WIDTH-1.
- value_in changes while value_ready=0 are ignored. The latched value is stable for a whole period.
- value_valid held with value_ready=0 causes no state change.
- rst asserted mid-period aborts immediately. The partial period is discarded and there is no period_done.

Optional Feature:
- Macro: SNG_LFSR_EN.
- Defined:
  - r = current state of a WIDTH-bit Fibonacci LFSR with de Bruijn zero-state insertion: feedback XORed with (state[WIDTH-2:0]==0). It visits all 2^WIDTH states per period, so the exactness rule still holds.
  - Taps: 3:{3,2}, 4:{4,3}, 5:{5,3}, 6:{6,5}, 7:{7,6}, 8:{8,6,5,4}.
  - LFSR is reloaded with SEED on every accept, so the sequence is identical each period.
  - Advances once per RUN cycle; holds in IDLE.
- Not defined: no LFSR registers; r = counter_sob.

Test Plan:
- Reset: rst=0 mid-RUN at counter_sob=17 → all outputs 0 immediately, value_ready=1 after release, no period_done.
- Single period, WIDTH=5, default source:
  - Stimulus: accept value_in=12.
  - Response: enable=1 for exactly 32 cycles, counter_sob 0..31, stream_out=1 at indices 0..11 only, period_done at index 31, then IDLE with enable=0.
- Boundaries: value_in=0 → 32 zeros. value_in=31 → 31 ones, zero at index 31.
- Back-to-back: value_valid held with 7 then 20 → second period starts the cycle after index 31 (counter_sob 31→0, enable stays 1); popcounts 7 and 20.
- Backpressure: value_valid=1 with value_in changing each cycle during RUN → no accept until index 31; the latched value equals value_in sampled on that cycle.
- SNG_LFSR_EN, SEED=1, value_in=16:
  - Popcount over 32 bits = 16.
  - The r sequence covers every value 0..31 exactly once.
  - Two consecutive periods are bit-identical.
